// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage.
// Multiply goes through a fixed-latency product register chain.
// Divide uses radix-2 restoring division, one quotient bit per cycle.
module mdu_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  localparam int unsigned W    = WIDTH;
  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned CMAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic          sgn_q, sgn_q_d, sgn_r, sgn_r_d;
  logic          done_d, div_zero_d;
  logic [RW-1:0] result_d;

  logic          accept_c, signed_c;
  logic [W-1:0]  abs_a_c, abs_b_c;
  logic [RW-1:0] ext_a_c, ext_b_c, prod_c, mul_out_c;
  logic [W:0]    rem_sh_c, diff_c;
  logic [W-1:0]  rem_n_c, quot_n_c, rem_fix_c, quot_fix_c;

  assign accept_c = start && (state == S_IDLE) && !flush;
  assign signed_c = ~op[0];

  // Operand conditioning: sign-extended product and divide magnitudes
  always_comb begin
    ext_a_c = signed_c ? {{W{src_a[W-1]}}, src_a} : {{W{1'b0}}, src_a};
    ext_b_c = signed_c ? {{W{src_b[W-1]}}, src_b} : {{W{1'b0}}, src_b};
    prod_c  = ext_a_c * ext_b_c;
    abs_a_c = (signed_c && src_a[W-1]) ? -src_a : src_a;
    abs_b_c = (signed_c && src_b[W-1]) ? -src_b : src_b;
  end

  // Product register chain; the last stage feeds the result register
  if (MUL_STAGES == 1) begin : g_mul_direct
    assign mul_out_c = prod_c;
  end else begin : g_mul_pipe
    logic [RW-1:0] pipe [MUL_STAGES-1];
    // Free-running shift; only the accepted op's slot is consumed
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(MUL_STAGES) - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= prod_c;
        for (int i = 1; i < int'(MUL_STAGES) - 1; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mul_out_c = pipe[MUL_STAGES-2];
  end

  // One restoring step plus the sign fix-up applied on the final step
  always_comb begin
    rem_sh_c = {rem_q, quot_q[W-1]};
    diff_c   = rem_sh_c - {1'b0, dvsr_q};
    if (!diff_c[W]) begin
      rem_n_c  = diff_c[W-1:0];
      quot_n_c = {quot_q[W-2:0], 1'b1};
    end else begin
      rem_n_c  = rem_sh_c[W-1:0];
      quot_n_c = {quot_q[W-2:0], 1'b0};
    end
    quot_fix_c = sgn_q ? -quot_n_c : quot_n_c;
    rem_fix_c  = sgn_r ? -rem_n_c : rem_n_c;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; flush always returns to idle
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (accept_c) state_d = op[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (done) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Output and datapath next values
  always_comb begin
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    result_d   = result;
    cnt_d      = cnt;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    sgn_q_d    = sgn_q;
    sgn_r_d    = sgn_r;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          cnt_d = CW'(1);
          if (!op[1]) begin
            if (MUL_STAGES == 1) begin
              done_d   = 1'b1;
              result_d = mul_out_c;
            end
          end else if (src_b == '0) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
            result_d   = {src_a, {W{1'b1}}};
          end else begin
            rem_d   = '0;
            quot_d  = abs_a_c;
            dvsr_d  = abs_b_c;
            sgn_q_d = signed_c & (src_a[W-1] ^ src_b[W-1]);
            sgn_r_d = signed_c & src_a[W-1];
          end
        end
      end
      S_MUL: begin
        if (!done && !flush) begin
          cnt_d = cnt + CW'(1);
          if (cnt == CW'(MUL_STAGES - 1)) begin
            done_d   = 1'b1;
            result_d = mul_out_c;
          end
        end
      end
      S_DIV: begin
        if (!done && !flush) begin
          cnt_d  = cnt + CW'(1);
          rem_d  = rem_n_c;
          quot_d = quot_n_c;
          if (cnt == CW'(W)) begin
            done_d   = 1'b1;
            result_d = {rem_fix_c, quot_fix_c};
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and divide datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
      cnt      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      sgn_q    <= 1'b0;
      sgn_r    <= 1'b0;
    end else begin
      busy     <= (state_d != S_IDLE);
      done     <= done_d;
      div_zero <= div_zero_d;
      result   <= result_d;
      cnt      <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      sgn_q    <= sgn_q_d;
      sgn_r    <= sgn_r_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (WIDTH=32, MUL_STAGES=4).
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_zero;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  mdu_iter #(.WIDTH(32), .MUL_STAGES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
    logic        dz;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, wait for done, check latency/result/flag and idle afterwards
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat = 0;
    op = v.op; src_a = v.a; src_b = v.b; start = 1'b1;
    tick();
    start = 1'b0; src_a = 32'hA5A5_5A5A; src_b = 32'h5A5A_A5A5; op = ~v.op;
    chk($sformatf("v%0d busy_c1", idx), 64'(busy), 64'd1);
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      tick();
    end
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d result", idx), result, v.res);
    chk($sformatf("v%0d div_zero", idx), 64'(div_zero), 64'(v.dz));
    tick();
    chk($sformatf("v%0d busy_after", idx), 64'(busy), 64'd0);
    chk($sformatf("v%0d done_after", idx), 64'(done), 64'd0);
  endtask

  // Count done pulses over n cycles
  task automatic count_done(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (done) seen++;
      tick();
    end
  endtask

  initial begin
    int seen;
    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 4, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0};
    vecs[3]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, 33, 1'b0};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 1'b0};
    vecs[5]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF, 1, 1'b1};
    vecs[6]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFDD, 4, 1'b0};
    vecs[7]  = '{2'b01, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 4, 1'b0};
    vecs[8]  = '{2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 33, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 33, 1'b0};
    vecs[10] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, 1, 1'b1};
    vecs[11] = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 64'hFFFF_FFF8_FFFF_FFFF, 1, 1'b1};
    vecs[12] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4, 1'b0};

    rst = 1'b1; flush = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    tick(); tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    rst = 1'b0;
    tick();

    // Back-to-back: each op starts in the cycle after the previous done
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Flush in the done cycle: done still shows, then idle
    op = 2'b01; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    chk("flush_in_done done", 64'(done), 64'd1);
    chk("flush_in_done result", result, 64'd15);
    tick(); flush = 1'b0;
    chk("flush_in_done busy", 64'(busy), 64'd0);
    chk("flush_in_done done_next", 64'(done), 64'd0);

    // Flush one cycle before done: no done, result kept
    op = 2'b01; src_a = 32'd4; src_b = 32'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_mul busy", 64'(busy), 64'd0);
    count_done(8, seen);
    chk("flush_mul no_done", 64'(seen), 64'd0);
    chk("flush_mul result", result, 64'd15);

    // Start while busy is ignored and not queued
    op = 2'b01; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    op = 2'b11; src_a = 32'd1; src_b = 32'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("busy_start done", 64'(done), 64'd1);
    chk("busy_start result", result, 64'd42);
    chk("busy_start div_zero", 64'(div_zero), 64'd0);
    tick();
    count_done(10, seen);
    chk("busy_start no_extra", 64'(seen), 64'd0);

    // Flush at cycle 10 of a divide
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_div busy", 64'(busy), 64'd0);
    count_done(40, seen);
    chk("flush_div no_done", 64'(seen), 64'd0);
    chk("flush_div result", result, 64'd42);

    // flush and start together: start dropped
    op = 2'b01; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    tick(); start = 1'b0; flush = 1'b0;
    chk("flush_start busy", 64'(busy), 64'd0);
    count_done(8, seen);
    chk("flush_start no_done", 64'(seen), 64'd0);

    // Asynchronous reset mid-multiply
    op = 2'b00; src_a = 32'd7; src_b = 32'hFFFF_FFFB; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid busy", 64'(busy), 64'd0);
    chk("rst_mid done", 64'(done), 64'd0);
    chk("rst_mid result", result, 64'd0);
    tick(); rst = 1'b0;
    count_done(8, seen);
    chk("rst_mid no_done", 64'(seen), 64'd0);
    chk("rst_mid result_after", result, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
